// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   sas_state_t   : sequencer state encoding (IDLE=0, RUN=1, DONE=2; code 3 is unused)
//   ALU_OP_ADDSUB : CPU ALU op code that routes add/sub requests to this unit
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    SAS_IDLE = 2'd0,
    SAS_RUN  = 2'd1,
    SAS_DONE = 2'd2
  } sas_state_t;

  localparam logic [3:0] ALU_OP_ADDSUB = 4'h1;

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/response bundle between the CPU datapath and the serial add/sub unit.
//   master : CPU side, drives start/sub/a/b, observes busy/done/sum/cout/overflow/zero
//   slave  : add/sub unit side
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow, zero
  );
endinterface

// File: rtl/serial_add_sub_fa.sv
// One-bit full adder; the only arithmetic cell in the serial add/sub unit.
//   x, y, cin : operand bits and carry in
//   sum, cout : sum bit and carry out
module full_adder_1bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract sequencer. Latches two WIDTH-bit operands and feeds
// them LSB first through a single full-adder cell, one bit per clock, with the
// carry held in a flop between bits. Subtraction is a + ~b + 1 (carry seeded
// with 1).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_add_sub_if (start/sub/a/b in;
//          busy/done/sum/cout/overflow/zero out, all registered)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SAS_IDLE | waiting for start; result outputs hold last values
// SAS_RUN  | one operand bit per edge, exactly WIDTH edges
// SAS_DONE | one-cycle done pulse; a start here is accepted back-to-back
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_add_sub_if.slave     bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);

  sas_state_t       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    bitcnt;
  logic             carry;
  logic             c_msb;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] result_next;

  full_adder_1bit u_fa (
    .x    (opa[0]),
    .y    (opb[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
  assign result_next = {fa_sum, result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SAS_IDLE;
      opa          <= '0;
      opb          <= '0;
      result       <= '0;
      bitcnt       <= '0;
      carry        <= 1'b0;
      c_msb        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
    end else begin
      case (state)
        SAS_IDLE, SAS_DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            opa      <= bus.a;
            opb      <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            bitcnt   <= '0;
            bus.busy <= 1'b1;
            state    <= SAS_RUN;
          end else begin
            bus.busy <= 1'b0;
            state    <= SAS_IDLE;
          end
        end

        SAS_RUN: begin
          opa    <= opa >> 1;
          opb    <= opb >> 1;
          result <= result_next;
          carry  <= fa_cout;
          bitcnt <= bitcnt + CW'(1);
          // Carry out of bit WIDTH-2 is the carry into the MSB; needed for signed overflow.
          if (bitcnt == PENULT_BIT) begin
            c_msb <= fa_cout;
          end
          if (bitcnt == LAST_BIT) begin
            bus.sum      <= result_next;
            bus.cout     <= fa_cout;
            bus.overflow <= c_msb ^ fa_cout;
            bus.zero     <= (result_next == '0);
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= SAS_DONE;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= SAS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
module tb_serial_add_sub;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic prev_done = 1'b0;

  serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: wide arithmetic, independent of the serial datapath.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    exp_t e;
    logic [7:0] bb;
    logic [8:0] full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
    e.s  = full[7:0];
    e.c  = full[8];
    e.v  = (a[7] == bb[7]) && (full[7] != a[7]);
    e.z  = (full[7:0] == 8'd0);
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents done.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high two cycles in a row at %0t", $time);
      end
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done with empty scoreboard at %0t", $time);
      end else begin
        e = q.pop_front();
        if (bus.sum !== e.s || bus.cout !== e.c || bus.overflow !== e.v || bus.zero !== e.z) begin
          errors++;
          $display("FAIL result: got sum=%0h c=%0b v=%0b z=%0b expected sum=%0h c=%0b v=%0b z=%0b",
                   bus.sum, bus.cout, bus.overflow, bus.zero, e.s, e.c, e.v, e.z);
        end
      end
    end
    prev_done = bus.done;
  end

  // Caller is at a negedge. Issues start, waits for done, checks latency and busy length.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic [7:0] es, input logic ec, input logic ev, input logic ez);
    exp_t e;
    int   cyc;
    int   busy_cnt;
    e.s = es; e.c = ec; e.v = ev; e.z = ez;
    q.push_back(e);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.sub = sub;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    while (!bus.done && cyc < 30) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, WIDTH);
    chk("busy_cycles", busy_cnt, WIDTH);
  endtask

  initial begin
    int ndone;
    exp_t m;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;

    // 1: reset with start asserted during reset
    rst = 1'b1;
    bus.start = 1'b1; bus.a = 8'h3C; bus.b = 8'h05;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_zero", bus.zero, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    // 2-4: directed add/sub vectors
    do_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    do_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_sum_idle", bus.sum, 8'h7F);

    // 5: start while busy ignored, then back-to-back start on the DONE cycle
    m.s = 8'h46; m.c = 1'b0; m.v = 1'b0; m.z = 1'b0;
    q.push_back(m);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("hold_sum_run", bus.sum, 8'h7F);
    chk("busy_mid_run", bus.busy, 1);
    ndone = 0;
    while (!bus.done && ndone < 30) begin
      @(negedge clk);
      ndone++;
    end
    chk("ignored_start_done", bus.done, 1);
    do_op(8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);

    // 6: reset mid-run aborts with no done
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_sum", bus.sum, 0);
    chk("abort_cout", bus.cout, 0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);

    // Random operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic rs;
      exp_t re;
      int gap;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      re = model(ra, rb, rs);
      do_op(ra, rb, rs, re.s, re.c, re.v, re.z);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
